// File: rtl/store_checker_pkg.sv
// Shared types for the data-memory store checker: verdict states and
// diagnostic fail codes.
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_BAD_ADDR  = 3'd1;
  localparam logic [2:0] FC_BAD_DATA  = 3'd2;
  localparam logic [2:0] FC_TIMEOUT   = 3'd3;
  localparam logic [2:0] FC_BAD_ORDER = 3'd4;

endpackage

// File: rtl/store_expect_match.sv
// Combinational comparison of one store against the expected-store table:
// per-entry address hits, per-entry data equality, and the lowest unmatched hit.
module store_expect_match #(
  parameter int NUM_EXP = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr_i,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data_i,
  input  logic [NUM_EXP-1:0]        matched_i,
  input  logic [ADDR_W-1:0]         dataadr_i,
  input  logic [DATA_W-1:0]         writedata_i,
  output logic [NUM_EXP-1:0]        addrHit_o,
  output logic [NUM_EXP-1:0]        dataEq_o,
  output logic                      unmHit_o,
  output logic [IDX_W-1:0]          unmIdx_o,
  output logic                      unmDataEq_o
);

  logic [NUM_EXP-1:0] hit;
  logic [NUM_EXP-1:0] eq;

  always_comb begin
    hit         = '0;
    eq          = '0;
    unmHit_o    = 1'b0;
    unmIdx_o    = '0;
    unmDataEq_o = 1'b0;
    // Scan downwards so the lowest unmatched index is the one left selected.
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      hit[i] = (exp_addr_i[i*ADDR_W +: ADDR_W] == dataadr_i);
      eq[i]  = (exp_data_i[i*DATA_W +: DATA_W] == writedata_i);
      if (hit[i] && !matched_i[i]) begin
        unmHit_o    = 1'b1;
        unmIdx_o    = IDX_W'(i);
        unmDataEq_o = eq[i];
      end
    end
  end

  assign addrHit_o = hit;
  assign dataEq_o  = eq;

endmodule

// File: rtl/store_checker.sv
// Monitor on the data-memory write bus: checks stores against an expected
// table, tolerates a scratch window, and latches a sticky verdict.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_EXP    = 4,
  parameter int ORDERED    = 1,
  parameter int SCRATCH_LO = 80,
  parameter int SCRATCH_HI = 80,
  parameter int TIMEOUT    = 1024,
  localparam int CNT_W     = $clog2(NUM_EXP + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memwrite,
  input  logic [ADDR_W-1:0]         dataadr,
  input  logic [DATA_W-1:0]         writedata,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [2:0]                fail_code,
  output logic [CNT_W-1:0]          match_cnt,
  output logic [ADDR_W-1:0]         fail_addr,
  output logic [DATA_W-1:0]         fail_data
);

  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    matchCnt_q, matchCnt_d;
  logic [NUM_EXP-1:0]  bitmap_q, bitmap_d;
  logic [TW-1:0]       cycCnt_q, cycCnt_d;
  logic [2:0]          failCode_q, failCode_d;
  logic [ADDR_W-1:0]   failAddr_q, failAddr_d;
  logic [DATA_W-1:0]   failData_q, failData_d;

  logic [NUM_EXP-1:0]  addrHit, dataEq;
  logic                unmHit, unmDataEq;
  logic [IDX_W-1:0]    unmIdx;

  store_expect_match #(
    .NUM_EXP(NUM_EXP),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .exp_addr_i (exp_addr),
    .exp_data_i (exp_data),
    .matched_i  (bitmap_q),
    .dataadr_i  (dataadr),
    .writedata_i(writedata),
    .addrHit_o  (addrHit),
    .dataEq_o   (dataEq),
    .unmHit_o   (unmHit),
    .unmIdx_o   (unmIdx),
    .unmDataEq_o(unmDataEq)
  );

  logic [NUM_EXP-1:0] curSel, unmSel, setMask;
  logic               curHit, curEq, oldHit, oldEq, inScratch, lastMatch, timeUp;
  logic               matchNow, storeFail;
  logic [2:0]         storeCode;

  always_comb begin
    curSel = '0;
    unmSel = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      curSel[i] = (matchCnt_q == CNT_W'(i));
      unmSel[i] = (unmIdx == IDX_W'(i));
    end
  end

  assign curHit    = |(addrHit & curSel);
  assign curEq     = |(addrHit & dataEq & curSel);
  assign oldHit    = |(addrHit & bitmap_q);
  assign oldEq     = |(addrHit & dataEq & bitmap_q);
  assign inScratch = (dataadr >= ADDR_W'(SCRATCH_LO)) && (dataadr <= ADDR_W'(SCRATCH_HI));
  assign lastMatch = (matchCnt_q == CNT_W'(NUM_EXP - 1));
  assign timeUp    = (cycCnt_q == TW'(TIMEOUT - 1));

  // Classify the sampled store; earlier branches take precedence.
  always_comb begin
    matchNow  = 1'b0;
    storeFail = 1'b0;
    storeCode = FC_NONE;
    setMask   = '0;
    if (memwrite) begin
      if (ORDERED != 0) begin
        if (curHit && curEq) begin
          matchNow = 1'b1;
          setMask  = curSel;
        end else if (curHit) begin
          storeFail = 1'b1;
          storeCode = FC_BAD_DATA;
        end else if (unmHit) begin
          storeFail = 1'b1;
          storeCode = FC_BAD_ORDER;
        end else if (oldHit) begin
          storeFail = !oldEq;
          storeCode = oldEq ? FC_NONE : FC_BAD_DATA;
        end else if (!inScratch) begin
          storeFail = 1'b1;
          storeCode = FC_BAD_ADDR;
        end
      end else begin
        if (unmHit && unmDataEq) begin
          matchNow = 1'b1;
          setMask  = unmSel;
        end else if (oldHit) begin
          storeFail = !oldEq;
          storeCode = oldEq ? FC_NONE : FC_BAD_DATA;
        end else if (unmHit) begin
          storeFail = 1'b1;
          storeCode = FC_BAD_DATA;
        end else if (!inScratch) begin
          storeFail = 1'b1;
          storeCode = FC_BAD_ADDR;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    matchCnt_d = matchCnt_q;
    bitmap_d   = bitmap_q;
    cycCnt_d   = cycCnt_q;
    failCode_d = failCode_q;
    failAddr_d = failAddr_q;
    failData_d = failData_q;
    case (state_q)
      ST_RUN: begin
        cycCnt_d = cycCnt_q + TW'(1);
        if (matchNow) begin
          bitmap_d   = bitmap_q | setMask;
          matchCnt_d = matchCnt_q + CNT_W'(1);
        end
        // A completing match beats a same-cycle timeout.
        if (matchNow && lastMatch) begin
          state_d = ST_PASS;
        end else if (storeFail) begin
          state_d    = ST_FAIL;
          failCode_d = storeCode;
          failAddr_d = dataadr;
          failData_d = writedata;
        end else if (timeUp) begin
          state_d    = ST_FAIL;
          failCode_d = FC_TIMEOUT;
          failAddr_d = '0;
          failData_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      matchCnt_q <= '0;
      bitmap_q   <= '0;
      cycCnt_q   <= '0;
      failCode_q <= FC_NONE;
      failAddr_q <= '0;
      failData_q <= '0;
    end else begin
      state_q    <= state_d;
      matchCnt_q <= matchCnt_d;
      bitmap_q   <= bitmap_d;
      cycCnt_q   <= cycCnt_d;
      failCode_q <= failCode_d;
      failAddr_q <= failAddr_d;
      failData_q <= failData_d;
    end
  end

  assign done      = (state_q != ST_RUN);
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign fail_code = failCode_q;
  assign match_cnt = matchCnt_q;
  assign fail_addr = failAddr_q;
  assign fail_data = failData_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: three instances (single-entry, ordered
// two-entry with short timeout, unordered two-entry) sharing one store bus.
module tb_store_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, rstB, rstC, memwrite;
  logic [31:0] dataadr, writedata;

  localparam logic [31:0] EXP_A1 = 32'd84;
  localparam logic [31:0] EXP_D1 = 32'd7;
  localparam logic [63:0] EXP_A2 = {32'd92, 32'd84};
  localparam logic [63:0] EXP_D2 = {32'd1, 32'd7};

  logic        doneA, passA, failA, doneB, passB, failB, doneC, passC, failC;
  logic [2:0]  codeA, codeB, codeC;
  logic        cntA;
  logic [1:0]  cntB, cntC;
  logic [31:0] fAddrA, fDataA, fAddrB, fDataB, fAddrC, fDataC;

  store_checker #(.NUM_EXP(1), .ORDERED(1), .TIMEOUT(1024)) uA (
    .clk(clk), .reset(rstA), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_addr(EXP_A1), .exp_data(EXP_D1), .done(doneA), .pass(passA), .fail(failA),
    .fail_code(codeA), .match_cnt(cntA), .fail_addr(fAddrA), .fail_data(fDataA));

  store_checker #(.NUM_EXP(2), .ORDERED(1), .TIMEOUT(16)) uB (
    .clk(clk), .reset(rstB), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_addr(EXP_A2), .exp_data(EXP_D2), .done(doneB), .pass(passB), .fail(failB),
    .fail_code(codeB), .match_cnt(cntB), .fail_addr(fAddrB), .fail_data(fDataB));

  store_checker #(.NUM_EXP(2), .ORDERED(0), .TIMEOUT(1024)) uC (
    .clk(clk), .reset(rstC), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_addr(EXP_A2), .exp_data(EXP_D2), .done(doneC), .pass(passC), .fail(failC),
    .fail_code(codeC), .match_cnt(cntC), .fail_addr(fAddrC), .fail_data(fDataC));

  int testsRun = 0;
  int testsFailed = 0;

  // Flags are packed as {done, pass, fail, fail_code}.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the store was sampled.
  task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    @(negedge clk);
    applyStimulus(1'b0, 0, 0);
    checkOutput("reset A flags", {doneA, passA, failA, codeA}, 6'b000000);
    checkOutput("reset A cnt", cntA, 0);
    checkOutput("reset A addr", fAddrA, 0);
    checkOutput("reset B flags", {doneB, passB, failB, codeB}, 6'b000000);
    checkOutput("reset C cnt", cntC, 0);

    // Scratch store ignored, then single match completes.
    rstA = 1'b1;
    applyStimulus(1'b1, 80, 3);
    checkOutput("T1 scratch flags", {doneA, passA, failA, codeA}, 6'b000000);
    checkOutput("T1 scratch cnt", cntA, 0);
    applyStimulus(1'b1, 84, 7);
    checkOutput("T1 pass flags", {doneA, passA, failA, codeA}, 6'b110000);
    checkOutput("T1 pass cnt", cntA, 1);
    applyStimulus(1'b1, 88, 1);
    checkOutput("T1 sticky flags", {doneA, passA, failA, codeA}, 6'b110000);
    checkOutput("T1 sticky addr", fAddrA, 0);

    // Wrong data on expected address.
    rstA = 1'b0;
    applyStimulus(1'b0, 0, 0);
    checkOutput("T2 reset flags", {doneA, passA, failA, codeA}, 6'b000000);
    rstA = 1'b1;
    applyStimulus(1'b1, 84, 6);
    checkOutput("T2 flags", {doneA, passA, failA, codeA}, 6'b101010);
    checkOutput("T2 addr", fAddrA, 84);
    checkOutput("T2 data", fDataA, 6);
    applyStimulus(1'b1, 84, 7);
    checkOutput("T2 sticky flags", {doneA, passA, failA, codeA}, 6'b101010);
    checkOutput("T2 sticky cnt", cntA, 0);
    checkOutput("T2 sticky data", fDataA, 6);

    // Unknown address.
    rstA = 1'b0;
    applyStimulus(1'b0, 0, 0);
    rstA = 1'b1;
    applyStimulus(1'b1, 88, 7);
    checkOutput("T3 flags", {doneA, passA, failA, codeA}, 6'b101001);
    checkOutput("T3 addr", fAddrA, 88);
    checkOutput("T3 data", fDataA, 7);
    rstA = 1'b0;

    // Ordered table hit out of order.
    rstB = 1'b1;
    applyStimulus(1'b1, 92, 1);
    checkOutput("T4 order flags", {doneB, passB, failB, codeB}, 6'b101100);
    checkOutput("T4 order addr", fAddrB, 92);
    checkOutput("T4 order cnt", cntB, 0);

    // Unordered table: any order, repeated identical store ignored.
    rstC = 1'b1;
    applyStimulus(1'b1, 92, 1);
    checkOutput("T4u first flags", {doneC, passC, failC, codeC}, 6'b000000);
    checkOutput("T4u first cnt", cntC, 1);
    applyStimulus(1'b1, 92, 1);
    checkOutput("T4u repeat flags", {doneC, passC, failC, codeC}, 6'b000000);
    checkOutput("T4u repeat cnt", cntC, 1);
    applyStimulus(1'b1, 84, 7);
    checkOutput("T4u pass flags", {doneC, passC, failC, codeC}, 6'b110000);
    checkOutput("T4u pass cnt", cntC, 2);
    rstC = 1'b0;
    applyStimulus(1'b0, 0, 0);
    rstC = 1'b1;
    applyStimulus(1'b1, 92, 1);
    applyStimulus(1'b1, 92, 5);
    checkOutput("T4u rewrite flags", {doneC, passC, failC, codeC}, 6'b101010);
    checkOutput("T4u rewrite data", fDataC, 5);
    checkOutput("T4u rewrite addr", fAddrC, 92);
    rstC = 1'b0;

    // Timeout after 16 RUN cycles.
    rstB = 1'b0;
    applyStimulus(1'b0, 0, 0);
    rstB = 1'b1;
    repeat (15) applyStimulus(1'b0, 0, 0);
    checkOutput("T5 before flags", {doneB, passB, failB, codeB}, 6'b000000);
    applyStimulus(1'b0, 0, 0);
    checkOutput("T5 timeout flags", {doneB, passB, failB, codeB}, 6'b101011);
    checkOutput("T5 timeout addr", fAddrB, 0);
    checkOutput("T5 timeout data", fDataB, 0);

    // Completion on the timeout cycle wins.
    rstB = 1'b0;
    applyStimulus(1'b0, 0, 0);
    rstB = 1'b1;
    applyStimulus(1'b1, 84, 7);
    repeat (14) applyStimulus(1'b0, 0, 0);
    checkOutput("T5 late flags", {doneB, passB, failB, codeB}, 6'b000000);
    checkOutput("T5 late cnt", cntB, 1);
    applyStimulus(1'b1, 92, 1);
    checkOutput("T5 win flags", {doneB, passB, failB, codeB}, 6'b110000);
    checkOutput("T5 win cnt", cntB, 2);

    // Reset mid-run discards progress and beats a same-cycle store.
    rstB = 1'b0;
    applyStimulus(1'b0, 0, 0);
    rstB = 1'b1;
    applyStimulus(1'b1, 84, 7);
    checkOutput("T6 partial cnt", cntB, 1);
    rstB = 1'b0;
    applyStimulus(1'b1, 92, 1);
    checkOutput("T6 reset flags", {doneB, passB, failB, codeB}, 6'b000000);
    checkOutput("T6 reset cnt", cntB, 0);
    checkOutput("T6 reset addr", fAddrB, 0);
    applyStimulus(1'b1, 84, 7);
    checkOutput("T6 held cnt", cntB, 0);
    rstB = 1'b1;
    applyStimulus(1'b1, 84, 7);
    checkOutput("T6 replay cnt", cntB, 1);
    applyStimulus(1'b1, 84, 7);
    checkOutput("T6 earlier flags", {doneB, passB, failB, codeB}, 6'b000000);
    checkOutput("T6 earlier cnt", cntB, 1);
    applyStimulus(1'b1, 92, 1);
    checkOutput("T6 pass flags", {doneB, passB, failB, codeB}, 6'b110000);
    checkOutput("T6 pass cnt", cntB, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
